// File: rtl/mm_status_pkg.sv
// rtl/mm_status_pkg.sv - shared address constants, status magic values and register decode for mm_status_periph
package mm_status_pkg;

   localparam logic [31:0] DEF_STDOUT_ADDR = 32'h1000_0000;
   localparam logic [31:0] DEF_STATUS_ADDR = 32'h2000_0000;
   localparam logic [31:0] DEF_EXIT_ADDR   = 32'h2000_0004;
   localparam logic [31:0] DEF_CYCLE_ADDR  = 32'h1500_1000;

   localparam logic [31:0] TEST_PASS_MAGIC = 32'd123456789;
   localparam logic [31:0] TEST_FAIL_MAGIC = 32'd1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_STDOUT,
      SEL_STATUS,
      SEL_EXIT,
      SEL_CYCLE
   } reg_sel_e;

   // Word-granular match: the low two byte-address bits never take part.
   function automatic reg_sel_e decode_sel(
      input logic [31:0] addr,
      input logic [31:0] stdout_addr,
      input logic [31:0] status_addr,
      input logic [31:0] exit_addr,
      input logic [31:0] cycle_addr
   );
      reg_sel_e sel;
      sel = SEL_NONE;
      if (addr[31:2] == stdout_addr[31:2])      sel = SEL_STDOUT;
      else if (addr[31:2] == status_addr[31:2]) sel = SEL_STATUS;
      else if (addr[31:2] == exit_addr[31:2])   sel = SEL_EXIT;
      else if (addr[31:2] == cycle_addr[31:2])  sel = SEL_CYCLE;
      return sel;
   endfunction

endpackage

// File: rtl/mm_status_fifo.sv
// rtl/mm_status_fifo.sv - synchronous FIFO with registered storage, wrapping pointers and occupancy count
module mm_status_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem[rd_ptr];
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;

   // Storage is cleared too so the head output reads zero straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/mm_status_periph.sv
// rtl/mm_status_periph.sv - memory-mapped test status/exit/stdout responder; MM_STATUS_CYCLE_CNT_EN adds a readable cycle counter
module mm_status_periph
   import mm_status_pkg::*;
#(
   parameter logic [31:0] STDOUT_ADDR = DEF_STDOUT_ADDR,
   parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
   parameter logic [31:0] EXIT_ADDR   = DEF_EXIT_ADDR,
   parameter logic [31:0] CYCLE_ADDR  = DEF_CYCLE_ADDR,
   parameter int          FIFO_DEPTH  = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        stdout_valid_o,
   output logic [7:0]  stdout_char_o,
   input  logic        stdout_ready_i,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   reg_sel_e      sel;
   logic          gnt;
   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] fifo_free;
   logic [7:0]    fifo_head;
   logic          rvalid_q;
   logic [31:0]   rdata_q;
   logic [31:0]   rdata_d;
   logic          passed_q;
   logic          failed_q;
   logic          exit_valid_q;
   logic [31:0]   exit_value_q;
   logic          unused_bits;

   assign unused_bits = ^{data_be_i[3:1]};

   always_comb sel = decode_sel(data_addr_i, STDOUT_ADDR, STATUS_ADDR, EXIT_ADDR, CYCLE_ADDR);

   // A stdout store into a full FIFO stalls; a same-cycle pop does not release it.
   assign gnt  = data_req_i && !(sel == SEL_STDOUT && data_we_i && fifo_full);
   assign push = gnt && data_we_i && (sel == SEL_STDOUT) && data_be_i[0];
   assign fifo_free = CW'(FIFO_DEPTH) - fifo_count;

   mm_status_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (data_wdata_i[7:0]),
      .pop       (stdout_ready_i),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

`ifdef MM_STATUS_CYCLE_CNT_EN
   logic [31:0] cycle_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) cycle_q <= '0;
      else       cycle_q <= cycle_q + 32'd1;
   end
`endif

   always_comb begin
      rdata_d = '0;
      if (!data_we_i) begin
         case (sel)
            SEL_STATUS: rdata_d = {30'b0, failed_q, passed_q};
            SEL_EXIT:   rdata_d = exit_value_q;
            SEL_STDOUT: rdata_d = 32'(fifo_free);
`ifdef MM_STATUS_CYCLE_CNT_EN
            SEL_CYCLE:  rdata_d = cycle_q;
`else
            SEL_CYCLE:  rdata_d = '0;
`endif
            default:    rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         passed_q     <= 1'b0;
         failed_q     <= 1'b0;
         exit_valid_q <= 1'b0;
         exit_value_q <= '0;
      end else begin
         rvalid_q <= gnt;
         if (gnt) rdata_q <= rdata_d;
         if (gnt && data_we_i) begin
            if (sel == SEL_STATUS && data_wdata_i == TEST_PASS_MAGIC) passed_q <= 1'b1;
            if (sel == SEL_STATUS && data_wdata_i == TEST_FAIL_MAGIC) failed_q <= 1'b1;
            if (sel == SEL_EXIT && !exit_valid_q) begin
               exit_valid_q <= 1'b1;
               exit_value_q <= data_wdata_i;
            end
         end
      end
   end

   assign data_gnt_o     = gnt;
   assign data_rvalid_o  = rvalid_q;
   assign data_rdata_o   = rdata_q;
   assign stdout_valid_o = !fifo_empty;
   assign stdout_char_o  = fifo_head;
   assign tests_passed_o = passed_q;
   assign tests_failed_o = failed_q;
   assign exit_valid_o   = exit_valid_q;
   assign exit_value_o   = exit_value_q;

endmodule

// File: doc/mm_status_periph.md
# mm_status_periph

Memory-mapped test-status responder on the core data bus inside the simulation wrapper. It accepts core stores and loads via the req/gnt/rvalid data interface. It produces the sticky pass/fail/exit signals the testbench monitors each clock edge, and buffers stdout characters in a FIFO drained through a valid/ready port. It is the device side of the testbench's pass/fail/exit monitoring.

## Interface
- Reset: one clock `clk_i`; reset `rst_i` is synchronous and active-high.
- Parameters:
  - `STDOUT_ADDR`, default 32'h1000_0000: word address of the stdout register.
  - `STATUS_ADDR`, default 32'h2000_0000: word address of the test status register.
  - `EXIT_ADDR`, default 32'h2000_0004: word address of the exit register.
  - `CYCLE_ADDR`, default 32'h1500_1000: word address of the cycle counter (read-only).
  - `FIFO_DEPTH`, default 8: stdout FIFO entries; must be a power of two, at least 2.
- Ports:
  - `clk_i` in 1: clock.
  - `rst_i` in 1: synchronous active-high reset.
  - `data_req_i` in 1: request; held until granted.
  - `data_addr_i` in 32: byte address; bits [1:0] ignored.
  - `data_we_i` in 1: 1 = store.
  - `data_be_i` in 4: byte enables.
  - `data_wdata_i` in 32: store data.
  - `data_gnt_o` out 1: request accepted this cycle.
  - `data_rvalid_o` out 1: response, one cycle after grant.
  - `data_rdata_o` out 32: load data, valid with `data_rvalid_o`.
  - `stdout_valid_o` out 1: FIFO head character available.
  - `stdout_char_o` out 8: FIFO head character.
  - `stdout_ready_i` in 1: sink consumes head when high with valid.
  - `tests_passed_o` out 1: sticky pass.
  - `tests_failed_o` out 1: sticky fail.
  - `exit_valid_o` out 1: sticky exit seen.
  - `exit_value_o` out 32: latched exit code.

## Operation
- Grant is combinational: `data_gnt_o = data_req_i`, except a stdout store while the FIFO is full, which gets gnt=0. That request stalls; no bypass, even if a pop occurs in the same cycle.
- Every grant produces exactly one `data_rvalid_o` pulse on the next cycle, for both loads and stores. At most one outstanding transaction.
- **Stdout store** with `data_be_i[0]=1`: pushes `data_wdata_i[7:0]`. With `be[0]=0`: granted, nothing pushed.
- **Status store**:
  - wdata 32'd123456789 sets `tests_passed_o`.
  - wdata 32'd1 sets `tests_failed_o`.
  - Any other value is ignored.
  - Both flags may be set; once set they stay set until reset.
- **Exit store**:
  - First store sets `exit_valid_o` and latches `exit_value_o <= data_wdata_i`; byte enables are ignored.
  - Later exit stores are ignored, so the first value is kept.
- **Loads**:
  - Status returns {30'b0, failed, passed}.
  - Exit returns `exit_value_o`.
  - Stdout returns {24'b0, free entry count, zero-extended}.
  - Unmapped addresses return 0.
- Stores to unmapped addresses and to the cycle counter are granted and discarded.
- FIFO behaviour:
  - Pop when `stdout_valid_o && stdout_ready_i`.
  - Push and pop in the same cycle on a non-full, non-empty FIFO keeps the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is one bit wider.
- Reset mid-transaction drops any pending rvalid and empties the FIFO.

## Timing
- All outputs are 0 in the cycle after reset is asserted, except `data_gnt_o`, which follows `data_req_i` combinationally. `stdout_valid_o` is 0.
- Latencies:
  - gnt to rvalid: exactly 1 cycle.
  - Status, exit and stdout-count register updates are visible on the clock edge that follows the grant.
  - Stdout push to `stdout_valid_o`: 1 cycle.
  - `stdout_char_o` is driven directly from FIFO storage (registered).
  - Full to not-full: gnt for a stalled stdout store rises in the cycle after the pop.

## Configuration
- `MM_STATUS_CYCLE_CNT_EN` defined:
  - A 32-bit free-running counter is present. It resets to 0, increments every cycle and wraps 32'hFFFF_FFFF to 0.
  - It is readable at `CYCLE_ADDR`; the value returned is the count at the grant cycle.
- `MM_STATUS_CYCLE_CNT_EN` undefined:
  - No counter logic.
  - `CYCLE_ADDR` behaves as unmapped (reads 0).

## Structure
- Package `mm_status_pkg` holds:
  - The default address constants.
  - `TEST_PASS_MAGIC` = 32'd123456789 and `TEST_FAIL_MAGIC` = 32'd1.
  - A register-select enum: NONE, STDOUT, STATUS, EXIT, CYCLE.
- One sub-module, `mm_status_fifo`: a synchronous FIFO parameterized by width and depth, with push/pop/full/empty/count.
- Address decode, response register and sticky flags live in the top.

## Test plan
1. Reset, then store 123456789 to STATUS_ADDR -> gnt same cycle; rvalid next cycle; `tests_passed_o`=1 on the following edge and stays 1; `tests_failed_o`=0.
2. Store 42 to STATUS_ADDR, then 1 -> first is ignored; `tests_failed_o`=1 after the second; a load of STATUS_ADDR returns 32'h2.
3. Store 7 then 0 to EXIT_ADDR -> `exit_valid_o`=1 and `exit_value_o`=7, held after the second store.
4. With `stdout_ready_i`=0, store 'A'..'I' (9 chars, FIFO_DEPTH 8):
   - The 9th store gets gnt=0 and stalls.
   - Raising ready drains 'A' first, the 9th is granted the next cycle, and the output order is A..I.
5. Load of an unmapped address and of STDOUT_ADDR with an empty FIFO -> rdata 0 and 8 respectively, each with one rvalid.
6. With `MM_STATUS_CYCLE_CNT_EN`: two CYCLE_ADDR loads granted 10 cycles apart -> the rdata values differ by 10. Without the macro -> both read 0.
